// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite pixel output stage.
package sprite_pkg;

    localparam int unsigned SPR_PIX = 16;
    localparam int unsigned POS_W   = 9;
    localparam int unsigned SCL_W   = 4;
    localparam int unsigned COL_W   = 5;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CLR_W   = 2 * SPR_PIX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // palette[n] holds the colour for 2-bit pixel index n
    typedef logic [3:0][COL_W-1:0] palette_t;

    typedef struct packed {
        logic [POS_W-1:0] pos_x;
        logic [SCL_W-1:0] scl_x;
        logic             swp_x;
        palette_t         palette;
        logic [CLR_W-1:0] colors;
    } sprite_t;

endpackage

// File: rtl/sprite_pix_mux.sv
// Combinational pixel select (optional mirror) and palette lookup.
// SPRITE_TRANSPARENCY_EN makes pixel index 0 transparent.
module sprite_pix_mux
    import sprite_pkg::*;
(
    input  logic [CLR_W-1:0] colors,
    input  palette_t         palette,
    input  logic             swp,
    input  logic [IDX_W-1:0] idx,
    output logic [COL_W-1:0] color_c,
    output logic             valid_c
);

    logic [IDX_W-1:0] sel;
    logic [1:0]       pal_idx;

    always_comb begin
        sel     = swp ? (IDX_W'(SPR_PIX - 1) - idx) : idx;
        pal_idx = colors[{sel, 1'b0} +: 2];
`ifdef SPRITE_TRANSPARENCY_EN
        valid_c = (pal_idx != 2'd0);
        color_c = valid_c ? palette[pal_idx] : '0;
`else
        valid_c = 1'b1;
        color_c = palette[pal_idx];
`endif
    end

endmodule

// File: rtl/sprite_pixel_out.sv
// Sprite line pixel emitter: waits for the beam to reach posX, then emits 16 scaled pixels.
// Optional build macro: SPRITE_TRANSPARENCY_EN (index 0 transparent).
module sprite_pixel_out
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [POS_W-1:0] posX,
    input  logic [SCL_W-1:0] sclX,
    input  logic             swpX,
    input  logic [COL_W-1:0] bcolor1,
    input  logic [COL_W-1:0] bcolor2,
    input  logic [COL_W-1:0] bcolor3,
    input  logic [COL_W-1:0] bcolor4,
    input  logic [CLR_W-1:0] colors,
    input  logic [POS_W-1:0] hpos,
    input  logic             pix_en,
    output logic [COL_W-1:0] pix_color,
    output logic             pix_valid,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    sprite_t          spr_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [SCL_W-1:0] rep_q;
    logic [SCL_W-1:0] rep_d;
    logic [COL_W-1:0] pix_color_d;
    logic             pix_valid_d;
    logic             emit;
    logic             start_hit;
    logic             last_pix;
    logic [COL_W-1:0] mux_color;
    logic             mux_valid;

    assign start_hit = pix_en && (hpos == spr_q.pos_x);
    assign last_pix  = (idx_q == IDX_W'(SPR_PIX - 1)) && (rep_q == spr_q.scl_x);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state; load has priority over clr
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_ARMED;
        end else if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ARMED: if (start_hit) state_d = ST_DRAW;
                ST_DRAW:  if (pix_en && last_pix) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // counter advance and next output values
    always_comb begin
        idx_d       = idx_q;
        rep_d       = rep_q;
        emit        = 1'b0;
        pix_color_d = pix_color;
        pix_valid_d = pix_valid;
        if (load) begin
            idx_d = '0;
            rep_d = '0;
        end else if (!clr && pix_en) begin
            case (state_q)
                ST_ARMED: emit = start_hit;
                ST_DRAW: begin
                    if (!last_pix) begin
                        emit = 1'b1;
                        if (rep_q == spr_q.scl_x) begin
                            idx_d = idx_q + IDX_W'(1);
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + SCL_W'(1);
                        end
                    end
                end
                default: emit = 1'b0;
            endcase
        end
        if (state_d != ST_DRAW) begin
            pix_color_d = '0;
            pix_valid_d = 1'b0;
        end else if (emit) begin
            pix_color_d = mux_color;
            pix_valid_d = mux_valid;
        end
    end

    sprite_pix_mux u_mux (
        .colors  (spr_q.colors),
        .palette (spr_q.palette),
        .swp     (spr_q.swp_x),
        .idx     (idx_d),
        .color_c (mux_color),
        .valid_c (mux_valid)
    );

    // latched sprite fields, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            pix_color <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (load) begin
                spr_q.pos_x   <= posX;
                spr_q.scl_x   <= sclX;
                spr_q.swp_x   <= swpX;
                spr_q.palette <= {bcolor4, bcolor3, bcolor2, bcolor1};
                spr_q.colors  <= colors;
            end
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            pix_color <= pix_color_d;
            pix_valid <= pix_valid_d;
            busy      <= (state_d == ST_ARMED) || (state_d == ST_DRAW);
        end
    end

endmodule
